reservoir_mac: RTL and testbench

//  Pre-activation stage of one integer ESN reservoir neuron.

---
 rtl/esn_pkg.sv | 47 ++++
 rtl/reservoir_mac_sat_shift.sv | 32 +++
 rtl/reservoir_mac.sv | 130 +++++++++++++
 tb/tb_reservoir_mac.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/esn_pkg.sv
// Shared definitions for the integer ESN reservoir pipeline: default formats,
// MAC FSM state encoding and the rescale/saturate helper.
package esn_pkg;

    localparam int ESN_DATA_W = 32;
    localparam int ESN_FRAC   = 16;

    // Working widths of the saturation helper; callers sign-extend into / slice out of these.
    localparam int SAT_ACC_W  = 160;
    localparam int SAT_VAL_W  = 64;

    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_ISSUE = 4'b0010,
        S_DRAIN = 4'b0100,
        S_DONE  = 4'b1000
    } state_e;

    typedef struct packed {
        logic                        sat;
        logic signed [SAT_VAL_W-1:0] val;
    } sat_res_t;

    function automatic sat_res_t sat_to_width(input logic signed [SAT_ACC_W-1:0] acc,
                                              input int unsigned                 frac,
                                              input int unsigned                 data_w);
        logic signed [SAT_ACC_W-1:0] r;
        logic signed [SAT_ACC_W-1:0] hi;
        logic signed [SAT_ACC_W-1:0] lo;
        sat_res_t                    res;
        r  = acc >>> frac;
        hi = $signed((SAT_ACC_W'(1) << (data_w - 1)) - SAT_ACC_W'(1));
        // In two's complement the most negative value is the complement of the most positive.
        lo = ~hi;
        res.sat = 1'b0;
        res.val = SAT_VAL_W'(r);
        if (r > hi) begin
            res.sat = 1'b1;
            res.val = SAT_VAL_W'(hi);
        end else if (r < lo) begin
            res.sat = 1'b1;
            res.val = SAT_VAL_W'(lo);
        end
        return res;
    endfunction

endpackage

// File: rtl/reservoir_mac_sat_shift.sv
// Combinational arithmetic right shift by FRAC followed by a clamp to DATA_W,
// with a flag raised whenever the clamp engaged.
module sat_shift
    import esn_pkg::*;
#(
    parameter int ACC_W  = 68,
    parameter int DATA_W = ESN_DATA_W,
    parameter int FRAC   = ESN_FRAC
)(
    input  logic signed [ACC_W-1:0]  iAcc,
    output logic signed [DATA_W-1:0] oData,
    output logic                     oSat
);

    sat_res_t res;

    always_comb begin
        res = sat_to_width(SAT_ACC_W'(iAcc), $unsigned(FRAC), $unsigned(DATA_W));
    end

    assign oData = res.val[DATA_W-1:0];
    assign oSat  = res.sat;

    // Bits above DATA_W are pure sign extension once clamped.
    generate
        if (DATA_W < SAT_VAL_W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^res.val[SAT_VAL_W-1:DATA_W];
        end
    endgenerate

endmodule

// File: rtl/reservoir_mac.sv
// Serial multiply-accumulate for one ESN reservoir neuron: bias plus LEN
// weighted terms read from 1-cycle memories, rescaled and saturated.
module reservoir_mac
    import esn_pkg::*;
#(
    parameter  int DATA_W = ESN_DATA_W,
    parameter  int LEN    = 8,
    parameter  int FRAC   = ESN_FRAC,
    localparam int ADDR_W = (LEN > 1) ? $clog2(LEN) : 1,
    localparam int ACC_W  = 2 * DATA_W + $clog2(LEN) + 1
)(
    input  logic                     iClk,
    input  logic                     iRst_n,
    input  logic                     iStart,
    input  logic signed [DATA_W-1:0] iBias,
    output logic        [ADDR_W-1:0] oAddr,
    input  logic signed [DATA_W-1:0] iX,
    input  logic signed [DATA_W-1:0] iW,
    output logic signed [DATA_W-1:0] oData,
    output logic                     oValid,
    output logic                     oBusy,
    output logic                     oSat
);

    state_e                     state_q, state_d;
    logic        [ADDR_W-1:0]   cnt_q, cnt_d;
    logic signed [ACC_W-1:0]    acc_q, acc_d;
    logic                       dvld_q, dvld_d;
    logic signed [DATA_W-1:0]   data_q, data_d;
    logic                       sat_q, sat_d;
    logic                       valid_q, valid_d;
    logic                       busy_q, busy_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [DATA_W-1:0]   sat_data;
    logic                       sat_flag;
    logic                       last_addr;

    assign prod      = (2*DATA_W)'(iX) * (2*DATA_W)'(iW);
    assign last_addr = (cnt_q == ADDR_W'(LEN - 1));

    sat_shift #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W),
        .FRAC   (FRAC)
    ) u_sat_shift (
        .iAcc  (acc_q),
        .oData (sat_data),
        .oSat  (sat_flag)
    );

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (iStart) state_d = S_ISSUE;
            S_ISSUE: if (last_addr) state_d = S_DRAIN;
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // dvld marks cycles where iX/iW carry the term addressed one cycle earlier.
    always_comb begin
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        dvld_d  = (state_q == S_ISSUE);
        data_d  = data_q;
        sat_d   = sat_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        if (dvld_q) begin
            acc_d = acc_q + ACC_W'(prod);
        end
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    acc_d  = ACC_W'(iBias) <<< FRAC;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                end
            end
            S_ISSUE: begin
                cnt_d = last_addr ? '0 : cnt_q + ADDR_W'(1);
            end
            S_DONE: begin
                data_d  = sat_data;
                sat_d   = sat_flag;
                valid_d = 1'b1;
                busy_d  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            cnt_q   <= '0;
            acc_q   <= '0;
            dvld_q  <= 1'b0;
            data_q  <= '0;
            sat_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            dvld_q  <= dvld_d;
            data_q  <= data_d;
            sat_q   <= sat_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign oAddr  = cnt_q;
    assign oData  = data_q;
    assign oValid = valid_q;
    assign oBusy  = busy_q;
    assign oSat   = sat_q;

endmodule

// File: tb/tb_reservoir_mac.sv
// Bench for reservoir_mac: two instances (FRAC=0 and FRAC=16) share stimulus and
// memory contents; results are checked against a table and an arithmetic model.
module tb_reservoir_mac;

    localparam int DW  = 32;
    localparam int LEN = 4;
    localparam int AW  = 2;

    logic                 clk   = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 start = 1'b0;
    logic signed [DW-1:0] bias  = '0;
    logic signed [DW-1:0] xmem [LEN];
    logic signed [DW-1:0] wmem [LEN];

    logic [AW-1:0] addr0, addr16;
    logic [DW-1:0] x0, w0, x16, w16, data0, data16;
    logic          valid0, valid16, busy0, busy16, sat0, sat16;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic signed [DW-1:0] x [LEN];
        logic signed [DW-1:0] w [LEN];
        logic signed [DW-1:0] b;
        logic [DW-1:0]        e0;
        logic                 s0;
        logic [DW-1:0]        e16;
        logic                 s16;
    } vec_t;

    vec_t tbl [8];

    always #5 clk = ~clk;

    reservoir_mac #(.DATA_W(DW), .LEN(LEN), .FRAC(0)) dut0 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start), .iBias(bias), .oAddr(addr0),
        .iX(x0), .iW(w0), .oData(data0), .oValid(valid0), .oBusy(busy0), .oSat(sat0)
    );

    reservoir_mac #(.DATA_W(DW), .LEN(LEN), .FRAC(16)) dut16 (
        .iClk(clk), .iRst_n(rst_n), .iStart(start), .iBias(bias), .oAddr(addr16),
        .iX(x16), .iW(w16), .oData(data16), .oValid(valid16), .oBusy(busy16), .oSat(sat16)
    );

    // Registered-read memories, one read port per instance.
    always @(posedge clk) begin
        x0  <= xmem[addr0];
        w0  <= wmem[addr0];
        x16 <= xmem[addr16];
        w16 <= wmem[addr16];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_row(input int i,
                           input logic signed [DW-1:0] xa, xb, xc, xd,
                           input logic signed [DW-1:0] wa, wb, wc, wd,
                           input logic signed [DW-1:0] b,
                           input logic [DW-1:0] e0, input logic s0,
                           input logic [DW-1:0] e16, input logic s16);
        tbl[i].x   = '{xa, xb, xc, xd};
        tbl[i].w   = '{wa, wb, wc, wd};
        tbl[i].b   = b;
        tbl[i].e0  = e0;
        tbl[i].s0  = s0;
        tbl[i].e16 = e16;
        tbl[i].s16 = s16;
    endtask

    task automatic load_row(input int i);
        xmem = tbl[i].x;
        wmem = tbl[i].w;
        bias = tbl[i].b;
    endtask

    // Exact sum in wide arithmetic, then shift and clamp to the 32-bit signed range.
    function automatic logic [DW:0] model(input int frac);
        logic signed [127:0] s;
        s = 128'(bias) <<< frac;
        for (int k = 0; k < LEN; k++) s += 128'(xmem[k]) * 128'(wmem[k]);
        s = s >>> frac;
        if (s > 128'sh7FFF_FFFF)  return {1'b1, 32'h7FFF_FFFF};
        if (s < -128'sh8000_0000) return {1'b1, 32'h8000_0000};
        return {1'b0, s[31:0]};
    endfunction

    // One start pulse; checks address sequence, latency, result, pulse width and hold.
    task automatic run_check(input string name, input logic [DW-1:0] e0, input logic s0,
                             input logic [DW-1:0] e16, input logic s16);
        int n;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (n < 40 && !valid0 && !valid16) begin
            if (n < LEN) begin
                check({name, ".addr0"}, 64'(addr0), 64'(n));
                check({name, ".addr16"}, 64'(addr16), 64'(n));
            end
            if (n == 1) check({name, ".busy"}, 64'(busy0), 64'd1);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({name, ".latency"}, 64'(n), 64'(LEN + 2));
        check({name, ".valid0"}, 64'(valid0), 64'd1);
        check({name, ".valid16"}, 64'(valid16), 64'd1);
        check({name, ".data0"}, 64'(data0), 64'(e0));
        check({name, ".sat0"}, 64'(sat0), 64'(s0));
        check({name, ".data16"}, 64'(data16), 64'(e16));
        check({name, ".sat16"}, 64'(sat16), 64'(s16));
        @(negedge clk);
        check({name, ".pulse0"}, 64'(valid0), 64'd0);
        check({name, ".idle"}, 64'(busy0), 64'd0);
        check({name, ".hold0"}, 64'(data0), 64'(e0));
        check({name, ".hold16"}, 64'(data16), 64'(e16));
    endtask

    initial begin
        logic [DW:0] m0, m16;
        int nv, na, last;
        logic prev;

        for (int k = 0; k < LEN; k++) begin
            xmem[k] = '0;
            wmem[k] = '0;
        end

        set_row(0, 1, 2, 3, 4, 1, 1, 1, 1, 0, 32'd10, 1'b0, 32'd0, 1'b0);
        set_row(1, 32'h10000, 32'h10000, 32'h10000, 32'h10000,
                   32'h10000, 32'h10000, 32'h10000, 32'h10000, 32'h8000,
                   32'h7FFF_FFFF, 1'b1, 32'h0004_8000, 1'b0);
        set_row(2, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0,
                   32'h7FFF_FFFF, 1'b1, 32'h7FFF_FFFF, 1'b1);
        set_row(3, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF,
                   32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 0,
                   32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1);
        set_row(4, -3, 5, -7, 2, 4, -2, 1, -6, -1,
                   32'hFFFF_FFD6, 1'b0, 32'hFFFF_FFFE, 1'b0);
        set_row(5, 32'h7FFF_FFFF, 0, 0, 0, 1, 0, 0, 0, 0,
                   32'h7FFF_FFFF, 1'b0, 32'h0000_7FFF, 1'b0);
        set_row(6, 32'h8000_0000, 0, 0, 0, 1, 0, 0, 0, 0,
                   32'h8000_0000, 1'b0, 32'hFFFF_8000, 1'b0);
        set_row(7, 32'h7FFF_FFFF, 1, 0, 0, 1, 1, 0, 0, 0,
                   32'h7FFF_FFFF, 1'b1, 32'h0000_8000, 1'b0);

        #2 rst_n = 1'b0;
        #1;
        check("rst.data0", 64'(data0), 64'd0);
        check("rst.valid0", 64'(valid0), 64'd0);
        check("rst.busy0", 64'(busy0), 64'd0);
        check("rst.sat0", 64'(sat0), 64'd0);
        check("rst.addr0", 64'(addr0), 64'd0);
        check("rst.data16", 64'(data16), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            load_row(i);
            run_check($sformatf("row%0d", i), tbl[i].e0, tbl[i].s0, tbl[i].e16, tbl[i].s16);
        end

        // Start held high: each new start is taken on the edge that closes the oValid cycle.
        load_row(0);
        @(negedge clk);
        start = 1'b1;
        nv = 0; na = 0; last = -1; prev = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 19) start = 1'b0;
            if (valid0) begin
                nv++;
                check("tput.pulse", 64'(prev), 64'd0);
                check("tput.data", 64'(data0), 64'd10);
                if (last < 0) check("tput.first", 64'(i), 64'(LEN + 2));
                else          check("tput.period", 64'(i - last), 64'(LEN + 3));
                last = i;
            end
            if (addr0 == AW'(LEN - 1)) na++;
            prev = valid0;
        end
        check("tput.results", 64'(nv), 64'd3);
        check("tput.addr_last", 64'(na), 64'd3);

        // Reset two edges into a computation.
        load_row(4);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort.addr0", 64'(addr0), 64'd0);
        check("abort.busy0", 64'(busy0), 64'd0);
        check("abort.valid0", 64'(valid0), 64'd0);
        check("abort.data0", 64'(data0), 64'd0);
        check("abort.sat0", 64'(sat0), 64'd0);
        check("abort.busy16", 64'(busy16), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        repeat (12) begin
            @(negedge clk);
            if (valid0 || valid16) nv++;
        end
        check("abort.no_valid", 64'(nv), 64'd0);
        load_row(0);
        run_check("after_rst", 32'd10, 1'b0, 32'd0, 1'b0);

        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < LEN; k++) begin
                case (it % 3)
                    0: begin
                        xmem[k] = int'($urandom_range(2000)) - 1000;
                        wmem[k] = int'($urandom_range(2000)) - 1000;
                    end
                    1: begin
                        xmem[k] = int'($urandom_range(32'h0020_0000)) - 32'sh0010_0000;
                        wmem[k] = int'($urandom_range(32'h0020_0000)) - 32'sh0010_0000;
                    end
                    default: begin
                        xmem[k] = $urandom();
                        wmem[k] = $urandom();
                    end
                endcase
            end
            bias = (it % 3 == 2) ? $urandom() : int'($urandom_range(2000)) - 1000;
            m0  = model(0);
            m16 = model(16);
            run_check($sformatf("rand%0d", it), m0[DW-1:0], m0[DW], m16[DW-1:0], m16[DW]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
